cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU.
- Owns the program counter and instruction register.
- Runs req/ack handshakes to instruction and data memory.
- Gates the combinational decoder's strobes (reg write, mem write, pc load) so each fires exactly once, in the correct phase.

Parameters:
RESET_PC, 13'd0, PC value loaded on reset and on start from IDLE
TIMEOUT_CYCLES, 16, max cycles a req may wait for ack before bus error (min 1)
COUNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; leaves IDLE when high
halt_req  in  1  stop at next instruction boundary
imem_req  out  1  instruction fetch request at address pc
imem_ack  in  1  instruction memory ack; instr_rdata valid same cycle
instr_rdata  in  16  fetched instruction word
dmem_req  out  1  data memory request (LOAD/STORE)
dmem_we  out  1  high with dmem_req for STORE
dmem_ack  in  1  data memory ack
dec_reg_write_enable  in  1  decoder strobe
dec_pc_load  in  1  decoder strobe (already includes BLT flag)
dec_jump_address  in  13  decoder jump target
pc  out  13  current program counter
instruction  out  16  instruction register, drives decoder
reg_write_commit  out  1  register-file write enable, gated
busy  out  1  high in every state except IDLE/HALTED
halted  out  1  high in HALTED
bus_error  out  1  sticky, set on handshake timeout
retired_count  out  COUNT_WIDTH  instructions completed, wraps

Behaviour:
- Reset values:
  - state IDLE; pc=RESET_PC; instruction=16'h0000; retired_count=0.
  - All req/we/commit outputs 0; bus_error=0.
- Reset mid-handshake drops req on the next edge. No request is replayed.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1 until imem_ack is sampled high.
  - On the ack edge: instruction<=instr_rdata, go to DECODE.
  - imem_req is low in the cycle after the ack.
- DECODE: one settle cycle for decoder outputs. Then go to EXECUTE.
- EXECUTE, opcode = instruction[15:13]:
  - 000-011 (ALU): go to WRITEBACK.
  - 100 (LOAD): go to MEM, dmem_we=0.
  - 101 (STORE): go to MEM, dmem_we=1.
  - 110/111 (JUMP/BLT): pc<=dec_pc_load ? dec_jump_address : pc+1; retire; go to boundary.
  - BLT flag is sampled only in EXECUTE.
- MEM:
  - dmem_req held until dmem_ack is sampled.
  - LOAD goes to WRITEBACK.
  - STORE does pc<=pc+1, retires, then boundary.
- WRITEBACK:
  - reg_write_commit = dec_reg_write_enable for exactly one cycle.
  - pc<=pc+1, retire, boundary.
- Boundary:
  - halt_req=1 goes to HALTED; else FETCH.
  - halt_req is ignored mid-instruction.
  - HALTED exits only via reset.
- pc+1 wraps 8191 to 0.
- retired_count increments once per completed instruction and wraps at 2^COUNT_WIDTH.
- Zero-wait latency (cycles from FETCH entry to next FETCH):
  - ALU = 4; LOAD = 5; STORE = 4; JUMP/BLT = 3.
  - Each wait cycle on ack adds 1.
- Timeout:
  - A wait counter is cleared on entering FETCH/MEM.
  - If the counter reaches TIMEOUT_CYCLES without ack: drop req, set bus_error, go to HALTED.
  - The instruction is not retired and pc is unchanged.
- Ack while req=0 is ignored.
- reg_write_commit is never high outside WRITEBACK. dmem_we is never high without dmem_req.

Decomposition:
- Shared package cpu_pkg:
  - state enum seq_state_t.
  - opcode constants OP_AND..OP_BLT (3'b000..3'b111).
  - widths INSTR_W=16, PC_W=13.
- One sub-module, handshake_timer: wait counter plus timeout compare, reused for FETCH and MEM.

Test Plan:
- ADD at pc 0, zero-wait acks, run=1 -> reg_write_commit pulses once in cycle 4; pc=1; retired_count=1.
- LOAD with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles; commit after ack; total 8 cycles; pc=1.
- STORE -> dmem_req=dmem_we=1 until ack; reg_write_commit never asserts; pc+1.
- JUMP to 13'h1FF0, then BLT with dec_pc_load=0 -> pc=1FF0, then 1FF1.
- JUMP to 13'h1FFF with no jump, then pc+1 -> wrap to 0.
- Fault and halt handling:
  - imem_ack never asserted, TIMEOUT_CYCLES=16 -> bus_error=1, halted=1 after 16 wait cycles, imem_req=0.
  - halt_req pulsed during MEM -> instruction completes, then HALTED.
  - reset during FETCH -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU sequencer.
//   - seq_state_t : sequencer FSM states
//   - OP_*        : 3-bit opcodes held in instruction[15:13]
//   - INSTR_W/PC_W: instruction and program-counter widths
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 13;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6
  } seq_state_t;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_JUMP  = 3'b110;
  localparam logic [2:0] OP_BLT   = 3'b111;

  function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[15:13];
  endfunction

endpackage

// File: rtl/handshake_timer.sv
// Wait counter for one req/ack handshake, shared by instruction fetch and
// data access.
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_active       : a request is outstanding this cycle
//   i_ack          : acknowledge for the outstanding request
//   o_expired      : this is the last allowed wait cycle and no ack arrived
module handshake_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_active,
  input  logic i_ack,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // The count equals the number of completed wait cycles, so it is zero in
  // the first request cycle. Leaving the wait (inactive or ack) clears it,
  // which gives every new FETCH/MEM a fresh budget.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_active || i_ack) begin
      r_count <= '0;
    end else if (r_count != LAST) begin
      r_count <= r_count + CW'(1);
    end
  end

  // An ack in the final allowed cycle still wins over the timeout.
  assign o_expired = i_active && !i_ack && (r_count == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU. Owns the
// program counter and instruction register, runs the memory handshakes and
// gates the decoder strobes so each fires once in the right phase.
//   clk, reset            : clock, synchronous active-high reset
//   run, halt_req         : start from IDLE / stop at next instruction boundary
//   imem_req/ack, instr_rdata : instruction fetch handshake at address pc
//   dmem_req/we/ack       : data access handshake (LOAD/STORE)
//   dec_*                 : combinational decoder strobes and jump target
//   pc, instruction       : program counter, instruction register
//   reg_write_commit      : gated register-file write enable
//   busy, halted, bus_error, retired_count : status
//   dbg_state             : current FSM state
//
// Handshake: a req stays high from the first cycle of FETCH/MEM until the
// cycle in which its ack is sampled high at the rising edge; that edge
// completes the transfer (instr_rdata is captured on it) and req is low in
// the following cycle. An ack while the matching req is low has no effect.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC       = 13'd0,
  parameter int              TIMEOUT_CYCLES = 16,
  parameter int              COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   halt_req,
  output logic                   imem_req,
  input  logic                   imem_ack,
  input  logic [INSTR_W-1:0]     instr_rdata,
  output logic                   dmem_req,
  output logic                   dmem_we,
  input  logic                   dmem_ack,
  input  logic                   dec_reg_write_enable,
  input  logic                   dec_pc_load,
  input  logic [PC_W-1:0]        dec_jump_address,
  output logic [PC_W-1:0]        pc,
  output logic [INSTR_W-1:0]     instruction,
  output logic                   reg_write_commit,
  output logic                   busy,
  output logic                   halted,
  output logic                   bus_error,
  output logic [COUNT_WIDTH-1:0] retired_count,
  output seq_state_t             dbg_state
);

  seq_state_t             r_state;
  seq_state_t             w_next;
  logic [PC_W-1:0]        r_pc;
  logic [INSTR_W-1:0]     r_instr;
  logic [COUNT_WIDTH-1:0] r_retired;
  logic                   r_bus_error;

  logic       w_ir_load;
  logic       w_pc_inc;
  logic       w_pc_jump;
  logic       w_pc_reset;
  logic       w_retire;
  logic       w_set_err;
  logic       w_active;
  logic       w_ack;
  logic       w_expired;
  logic [2:0] w_opcode;
  seq_state_t w_boundary;

  assign w_opcode   = opcode_of(r_instr);
  assign w_boundary = halt_req ? S_HALTED : S_FETCH;
  assign w_active   = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ack      = (r_state == S_FETCH) ? imem_ack : dmem_ack;

  handshake_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_active (w_active),
    .i_ack    (w_ack),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    imem_req         = 1'b0;
    dmem_req         = 1'b0;
    dmem_we          = 1'b0;
    reg_write_commit = 1'b0;
    w_ir_load        = 1'b0;
    w_pc_inc         = 1'b0;
    w_pc_jump        = 1'b0;
    w_pc_reset       = 1'b0;
    w_retire         = 1'b0;
    w_set_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_pc_reset = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_ir_load = 1'b1;
          w_next    = S_DECODE;
        end else if (w_expired) begin
          w_set_err = 1'b1;
          w_next    = S_HALTED;
        end
      end
      S_DECODE: begin
        w_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (w_opcode)
          OP_LOAD, OP_STORE: w_next = S_MEM;
          OP_JUMP, OP_BLT: begin
            // dec_pc_load already folds in the BLT flag; it is only
            // consulted here, in the one EXECUTE cycle.
            w_pc_jump = dec_pc_load;
            w_pc_inc  = !dec_pc_load;
            w_retire  = 1'b1;
            w_next    = w_boundary;
          end
          default: w_next = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_opcode == OP_STORE);
        if (dmem_ack) begin
          if (w_opcode == OP_STORE) begin
            w_pc_inc = 1'b1;
            w_retire = 1'b1;
            w_next   = w_boundary;
          end else begin
            w_next = S_WRITEBACK;
          end
        end else if (w_expired) begin
          w_set_err = 1'b1;
          w_next    = S_HALTED;
        end
      end
      S_WRITEBACK: begin
        reg_write_commit = dec_reg_write_enable;
        w_pc_inc         = 1'b1;
        w_retire         = 1'b1;
        w_next           = w_boundary;
      end
      S_HALTED: begin
        w_next = S_HALTED;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_retired   <= '0;
      r_bus_error <= 1'b0;
    end else begin
      if (w_pc_reset) begin
        r_pc <= RESET_PC;
      end else if (w_pc_jump) begin
        r_pc <= dec_jump_address;
      end else if (w_pc_inc) begin
        r_pc <= r_pc + PC_W'(1);  // wraps 8191 -> 0
      end
      if (w_ir_load) begin
        r_instr <= instr_rdata;
      end
      if (w_retire) begin
        r_retired <= r_retired + COUNT_WIDTH'(1);
      end
      if (w_set_err) begin
        r_bus_error <= 1'b1;
      end
    end
  end

  assign pc            = r_pc;
  assign instruction   = r_instr;
  assign retired_count = r_retired;
  assign bus_error     = r_bus_error;
  assign busy          = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign halted        = (r_state == S_HALTED);
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
  import cpu_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [15:0] instr_rdata = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        dec_reg_write_enable = 1'b0;
  logic        dec_pc_load = 1'b0;
  logic [12:0] dec_jump_address = '0;
  logic [12:0] pc;
  logic [15:0] instruction;
  logic        reg_write_commit;
  logic        busy;
  logic        halted;
  logic        bus_error;
  logic [15:0] retired_count;
  seq_state_t  dbg_state;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr_rdata(instr_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .dec_reg_write_enable(dec_reg_write_enable), .dec_pc_load(dec_pc_load),
    .dec_jump_address(dec_jump_address), .pc(pc), .instruction(instruction),
    .reg_write_commit(reg_write_commit), .busy(busy), .halted(halted),
    .bus_error(bus_error), .retired_count(retired_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] instr;
    int          iwait;
    int          dwait;
    logic        dec_we;
    logic        pc_ld;
    logic [12:0] jaddr;
    logic        halt;
    int          exp_cyc;
    logic [12:0] exp_pc;
    int          exp_commit;
    int          exp_dreq;
    int          exp_dwe;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[10];

  // Runs one instruction starting at a negedge in FETCH. Acts as both
  // memories (ack after iwait/dwait wait cycles) and as the decoder.
  task automatic run_vec(input int idx, input vec_t v, input logic [15:0] exp_ret);
    int  cyc = 0;
    int  icnt = 0;
    int  dcnt = 0;
    int  commits = 0;
    int  dreq_cyc = 0;
    int  dwe_cyc = 0;
    bit  fetched = 0;
    bit  done = 0;
    dec_reg_write_enable = v.dec_we;
    dec_pc_load          = v.pc_ld;
    dec_jump_address     = v.jaddr;
    halt_req             = v.halt;
    instr_rdata          = v.instr;
    while (!done && cyc < 100) begin
      imem_ack = imem_req && (icnt == v.iwait);
      if (imem_ack) fetched = 1;
      if (imem_req) icnt++;
      dmem_ack = dmem_req && (dcnt == v.dwait);
      if (dmem_req) begin dcnt++; dreq_cyc++; end
      if (dmem_we) dwe_cyc++;
      #1;
      if (reg_write_commit) commits++;
      cyc++;
      step();
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (halted) done = 1;
      else if (imem_req && fetched) done = 1;
    end
    if (!done) chk($sformatf("v%0d_timeout", idx), 32'(cyc), 32'(v.exp_cyc));
    chk($sformatf("v%0d_cycles", idx), 32'(cyc), 32'(v.exp_cyc));
    chk($sformatf("v%0d_pc", idx), 32'(pc), 32'(v.exp_pc));
    chk($sformatf("v%0d_ir", idx), 32'(instruction), 32'(v.instr));
    chk($sformatf("v%0d_commits", idx), 32'(commits), 32'(v.exp_commit));
    chk($sformatf("v%0d_dmem_req", idx), 32'(dreq_cyc), 32'(v.exp_dreq));
    chk($sformatf("v%0d_dmem_we", idx), 32'(dwe_cyc), 32'(v.exp_dwe));
    chk($sformatf("v%0d_retired", idx), 32'(retired_count), 32'(exp_ret));
    chk($sformatf("v%0d_halted", idx), 32'(halted), 32'(v.exp_halted));
    halt_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int n;
    //          instr     iw dw we    pl    jaddr    halt  cyc pc       cm dr dw hlt
    vecs[0] = '{16'h4000, 0, 0, 1'b1, 1'b0, 13'h0000, 1'b0, 4, 13'h0001, 1, 0, 0, 1'b0}; // ADD
    vecs[1] = '{16'h8000, 0, 3, 1'b1, 1'b0, 13'h0000, 1'b0, 8, 13'h0002, 1, 4, 0, 1'b0}; // LOAD, 3 waits
    vecs[2] = '{16'hA000, 0, 1, 1'b1, 1'b0, 13'h0000, 1'b0, 5, 13'h0003, 0, 2, 2, 1'b0}; // STORE, we strobe gated
    vecs[3] = '{16'hC000, 0, 0, 1'b0, 1'b1, 13'h1FF0, 1'b0, 3, 13'h1FF0, 0, 0, 0, 1'b0}; // JUMP
    vecs[4] = '{16'hE000, 0, 0, 1'b0, 1'b0, 13'h0123, 1'b0, 3, 13'h1FF1, 0, 0, 0, 1'b0}; // BLT not taken
    vecs[5] = '{16'h0000, 2, 0, 1'b0, 1'b0, 13'h0000, 1'b0, 6, 13'h1FF2, 0, 0, 0, 1'b0}; // AND, 2 fetch waits
    vecs[6] = '{16'hC000, 0, 0, 1'b0, 1'b1, 13'h1FFF, 1'b0, 3, 13'h1FFF, 0, 0, 0, 1'b0}; // JUMP to top
    vecs[7] = '{16'h6000, 0, 0, 1'b1, 1'b0, 13'h0000, 1'b0, 4, 13'h0000, 1, 0, 0, 1'b0}; // SUB, pc wraps
    vecs[8] = '{16'hE000, 1, 0, 1'b0, 1'b1, 13'h0055, 1'b0, 4, 13'h0055, 0, 0, 0, 1'b0}; // BLT taken
    vecs[9] = '{16'hA000, 0, 2, 1'b0, 1'b0, 13'h0000, 1'b1, 6, 13'h0056, 0, 3, 3, 1'b1}; // STORE + halt_req

    @(negedge clk);
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(instruction), 32'd0);
    chk("rst_retired", 32'(retired_count), 32'd0);
    chk("rst_reqs", {29'd0, imem_req, dmem_req, dmem_we}, 32'd0);
    chk("rst_commit_err", {30'd0, reg_write_commit, bus_error}, 32'd0);

    // Acks with no request outstanding must be ignored.
    imem_ack = 1'b1; dmem_ack = 1'b1; instr_rdata = 16'hBEEF;
    step();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_ir", 32'(instruction), 32'd0);

    run = 1'b1;
    step();
    chk("start_fetch_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i], 16'(i + 1));
    chk("halt_busy", 32'(busy), 32'd0);
    step();
    chk("halt_sticky", 32'(halted), 32'd1);

    // Reset in the middle of a fetch handshake.
    do_reset();
    run = 1'b1;
    step();
    run_vec(10, vecs[0], 16'd1);
    step(); step(); step();
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_ir", 32'(instruction), 32'd0);
    chk("mid_rst_retired", 32'(retired_count), 32'd0);

    // Fetch that is never acknowledged.
    reset = 1'b0;
    run = 1'b1;
    step();
    n = 0;
    while (!halted && n < 100) begin
      if (imem_req) n++;
      step();
    end
    chk("to_req_cycles", 32'(n), 32'd16);
    chk("to_bus_error", 32'(bus_error), 32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_req_low", 32'(imem_req), 32'd0);
    chk("to_pc", 32'(pc), 32'd0);
    chk("to_retired", 32'(retired_count), 32'd0);

    do_reset();
    chk("clr_bus_error", 32'(bus_error), 32'd0);
    chk("clr_halted", 32'(halted), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
